// File: rtl/pac_epoch_scheduler_pkg.sv
// Shared types and defaults for the page-access-counter epoch scheduler.
// Encodings put the reset value of every enum at zero.
package ctrl_signal_types;

  typedef enum logic [0:0] {
    ZERO_OUT_COUNTER   = 1'b0,
    WRITE_BACK_COUNTER = 1'b1
  } updater_mode_t;

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_INIT_ZO_START = 4'd1,
    S_INIT_ZO_WAIT  = 4'd2,
    S_COUNT         = 4'd3,
    S_WB_START      = 4'd4,
    S_WB_WAIT       = 4'd5,
    S_ZO_START      = 4'd6,
    S_ZO_WAIT       = 4'd7,
    S_ADVANCE       = 4'd8,
    S_ERROR         = 4'd9
  } sched_state_t;

  localparam int PAC_NUM_BUF        = 4;
  localparam int PAC_TIMEOUT_CYCLES = 2 ** 20;
  localparam int PAC_EPOCH_W        = 32;

endpackage

// File: rtl/pac_epoch_scheduler_epoch_timer.sv
// Free-running epoch timer: pulses expire_o on the last cycle of each period.
// A zero period never expires; the count restarts on clear, expiry or stop.
module epoch_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         run_i,
  input  logic         clear_i,
  input  logic [W-1:0] period_i,
  output logic         expire_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;

  // >= rather than == so a period shortened below the running count still fires.
  assign expire_o = run_i && (period_i != '0) && (count_q >= (period_i - ONE));

  always_comb begin
    count_d = count_q + ONE;
    if (!run_i || clear_i || expire_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pac_epoch_scheduler.sv
// Epoch scheduler: drives the counter updater through write-back then zero-out
// once per epoch or per flush, rotating the DRAM destination across a buffer ring.
module pac_epoch_scheduler
  import ctrl_signal_types::*;
#(
  parameter int NUM_BUF        = PAC_NUM_BUF,
  parameter int TIMEOUT_CYCLES = PAC_TIMEOUT_CYCLES,
  parameter int EPOCH_W        = PAC_EPOCH_W
) (
  input  logic                       mclk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [EPOCH_W-1:0]         epoch_cycles,
  input  logic                       flush_req,
  input  logic [63:0]                buf_base,
  input  logic [63:0]                buf_stride,
  output logic                       updater_start,
  output updater_mode_t              updater_mode,
  output logic [63:0]                updater_buffer_addr,
  input  logic                       updater_done,
  output logic                       busy,
  output logic [EPOCH_W-1:0]         epoch_id,
  output logic [$clog2(NUM_BUF)-1:0] buf_idx,
  output logic                       wb_done,
  output logic [15:0]                overrun_cnt,
  output logic                       timeout_err,
  output sched_state_t               dbg_state
);

  localparam int IDX_W  = $clog2(NUM_BUF);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BUF - 1);

  sched_state_t        state_q, state_d;
  logic [EPOCH_W-1:0]  epoch_id_q, epoch_id_d;
  logic [IDX_W-1:0]    buf_idx_q, buf_idx_d;
  logic [15:0]         overrun_q, overrun_d;
  logic                timeout_err_q, timeout_err_d;
  logic                pending_q, pending_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  updater_mode_t       mode_q, mode_d;
  logic [63:0]         addr_q, addr_d;

  logic timer_run, timer_clear, timer_expire;
  logic in_wait, wait_timeout, trigger;

  assign in_wait      = state_q inside {S_INIT_ZO_WAIT, S_WB_WAIT, S_ZO_WAIT};
  assign wait_timeout = in_wait && !updater_done && (wait_cnt_q == WAIT_LAST);
  assign timer_run    = !(state_q inside {S_IDLE, S_ERROR});
  assign trigger      = timer_expire || flush_req || pending_q;

  epoch_timer #(.W(EPOCH_W)) u_epoch_timer (
    .clk_i    (mclk),
    .rst_i    (reset),
    .run_i    (timer_run),
    .clear_i  (timer_clear),
    .period_i (epoch_cycles),
    .expire_o (timer_expire)
  );

  // Updater handshake: updater_start is a single-cycle pulse in a *_START state;
  // mode/address hold until the matching updater_done pulse is seen in *_WAIT.
  always_comb begin
    state_d       = state_q;
    timer_clear   = 1'b0;
    updater_start = 1'b0;
    busy          = 1'b1;
    wb_done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (enable) state_d = S_INIT_ZO_START;
      end
      S_INIT_ZO_START: begin
        updater_start = 1'b1;
        state_d       = S_INIT_ZO_WAIT;
      end
      S_INIT_ZO_WAIT: begin
        if (updater_done) begin
          state_d     = S_COUNT;
          timer_clear = 1'b1;
        end else if (wait_timeout) begin
          state_d = S_ERROR;
        end
      end
      S_COUNT: begin
        busy = 1'b0;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (trigger) begin
          state_d     = S_WB_START;
          timer_clear = 1'b1;
        end
      end
      S_WB_START: begin
        updater_start = 1'b1;
        state_d       = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (updater_done)      state_d = S_ZO_START;
        else if (wait_timeout) state_d = S_ERROR;
      end
      S_ZO_START: begin
        updater_start = 1'b1;
        state_d       = S_ZO_WAIT;
      end
      S_ZO_WAIT: begin
        if (updater_done)      state_d = S_ADVANCE;
        else if (wait_timeout) state_d = S_ERROR;
      end
      S_ADVANCE: begin
        wb_done = 1'b1;
        state_d = enable ? S_COUNT : S_IDLE;
      end
      S_ERROR: begin
        busy = 1'b0;
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    epoch_id_d    = epoch_id_q;
    buf_idx_d     = buf_idx_q;
    overrun_d     = overrun_q;
    pending_d     = pending_q;
    mode_d        = mode_q;
    addr_d        = addr_q;
    wait_cnt_d    = in_wait ? (wait_cnt_q + 1'b1) : '0;
    timeout_err_d = timeout_err_q || ((state_d == S_ERROR) && (state_q != S_ERROR));
    if (state_q == S_ADVANCE) begin
      epoch_id_d = epoch_id_q + 1'b1;
      buf_idx_d  = (buf_idx_q == IDX_LAST) ? '0 : (buf_idx_q + 1'b1);
    end
    // Expiry while the updater is busy is lost, not queued.
    if (timer_expire && (state_q != S_COUNT) && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end
    if (state_q inside {S_IDLE, S_WB_START}) pending_d = 1'b0;
    if (flush_req && busy) pending_d = 1'b1;
    if (state_d != state_q) begin
      if (state_d == S_WB_START) begin
        mode_d = WRITE_BACK_COUNTER;
        addr_d = buf_base + (64'(buf_idx_q) * buf_stride);
      end else if (state_d inside {S_INIT_ZO_START, S_ZO_START}) begin
        mode_d = ZERO_OUT_COUNTER;
      end
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      epoch_id_q    <= '0;
      buf_idx_q     <= '0;
      overrun_q     <= '0;
      timeout_err_q <= 1'b0;
      pending_q     <= 1'b0;
      wait_cnt_q    <= '0;
      mode_q        <= ZERO_OUT_COUNTER;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      epoch_id_q    <= epoch_id_d;
      buf_idx_q     <= buf_idx_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      pending_q     <= pending_d;
      wait_cnt_q    <= wait_cnt_d;
      mode_q        <= mode_d;
      addr_q        <= addr_d;
    end
  end

  assign updater_mode        = mode_q;
  assign updater_buffer_addr = addr_q;
  assign epoch_id            = epoch_id_q;
  assign buf_idx             = buf_idx_q;
  assign overrun_cnt         = overrun_q;
  assign timeout_err         = timeout_err_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_pac_epoch_scheduler.sv
// Directed bench for pac_epoch_scheduler with a behavioural updater model.
module tb_pac_epoch_scheduler;
  import ctrl_signal_types::*;

  localparam int NUM_BUF = 4;
  localparam int TMO     = 64;
  localparam int EW      = 32;

  // ---------------- clock / reset ----------------
  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [EW-1:0] epoch_cycles = '0;
  logic          flush_req = 1'b0;
  logic [63:0]   buf_base = 64'h1000;
  logic [63:0]   buf_stride = 64'h40;
  logic          updater_done = 1'b0;

  logic          updater_start;
  updater_mode_t updater_mode;
  logic [63:0]   updater_buffer_addr;
  logic          busy;
  logic [EW-1:0] epoch_id;
  logic [1:0]    buf_idx;
  logic          wb_done;
  logic [15:0]   overrun_cnt;
  logic          timeout_err;
  sched_state_t  dbg_state;

  pac_epoch_scheduler #(
    .NUM_BUF(NUM_BUF), .TIMEOUT_CYCLES(TMO), .EPOCH_W(EW)
  ) dut (
    .mclk(mclk), .reset(reset), .enable(enable), .epoch_cycles(epoch_cycles),
    .flush_req(flush_req), .buf_base(buf_base), .buf_stride(buf_stride),
    .updater_start(updater_start), .updater_mode(updater_mode),
    .updater_buffer_addr(updater_buffer_addr), .updater_done(updater_done),
    .busy(busy), .epoch_id(epoch_id), .buf_idx(buf_idx), .wb_done(wb_done),
    .overrun_cnt(overrun_cnt), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  int unsigned cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // ---------------- updater model / start log ----------------
  int          done_lat = 10;
  bit          never_done = 1'b0;
  int          cnt = 0;
  int          wb_cnt = 0;
  logic [63:0] st_mode_q[$];
  logic [63:0] st_addr_q[$];
  int unsigned st_cyc_q[$];

  always @(negedge mclk) begin
    if (reset) begin
      cnt          = 0;
      updater_done = 1'b0;
    end else begin
      updater_done = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0 && !never_done) updater_done = 1'b1;
      end
      if (updater_start) begin
        st_mode_q.push_back(64'(updater_mode));
        st_addr_q.push_back(updater_buffer_addr);
        st_cyc_q.push_back(cyc);
        cnt = done_lat;
      end
      if (wb_done) wb_cnt = wb_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge mclk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    flush_req = 1'b0;
    repeat (3) tick();
    st_mode_q.delete();
    st_addr_q.delete();
    st_cyc_q.delete();
    wb_cnt     = 0;
    never_done = 1'b0;
    reset      = 1'b0;
    tick();
  endtask

  task automatic wait_state(input sched_state_t s, input int budget, input string tag);
    int k = 0;
    while (dbg_state !== s && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(dbg_state === s), 64'(1));
  endtask

  task automatic wait_wb(input int n, input int budget, input string tag);
    int k = 0;
    while (wb_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(wb_cnt >= n), 64'(1));
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  function automatic int count_wb();
    int c = 0;
    foreach (st_mode_q[i]) if (st_mode_q[i] == 64'(WRITE_BACK_COUNTER)) c++;
    return c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int unsigned t, c0;
    int n;

    // Reset values
    do_reset();
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    check("rst_start", 64'(updater_start), 64'(0));
    check("rst_mode", 64'(updater_mode), 64'(ZERO_OUT_COUNTER));
    check("rst_addr", updater_buffer_addr, 64'h0);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_epoch", 64'(epoch_id), 64'(0));
    check("rst_idx", 64'(buf_idx), 64'(0));
    check("rst_ovr", 64'(overrun_cnt), 64'(0));
    check("rst_tmo", 64'(timeout_err), 64'(0));

    // Bring-up and ring wrap: period 100, updater latency 10
    epoch_cycles = 100;
    done_lat     = 10;
    buf_base     = 64'h1000;
    buf_stride   = 64'h40;
    enable       = 1'b1;
    wait_wb(1, 400, "bringup_wb_done");
    check("bringup_nstarts", 64'(st_mode_q.size()), 64'(3));
    check("bringup_mode0", st_mode_q[0], 64'(ZERO_OUT_COUNTER));
    check("bringup_mode1", st_mode_q[1], 64'(WRITE_BACK_COUNTER));
    check("bringup_mode2", st_mode_q[2], 64'(ZERO_OUT_COUNTER));
    check("bringup_wb_lat", 64'(st_cyc_q[1] - st_cyc_q[0]), 64'(111));
    tick();
    check("bringup_epoch", 64'(epoch_id), 64'(1));
    check("bringup_idx", 64'(buf_idx), 64'(1));
    check("bringup_state", 64'(dbg_state), 64'(S_COUNT));

    exp_q = '{64'h1000, 64'h1040, 64'h1080, 64'h10C0, 64'h1000};
    wait_wb(5, 1000, "ring_wb_done");
    tick();
    check("ring_nstarts", 64'(st_mode_q.size()), 64'(11));
    for (int i = 1; i < 11; i += 2) begin
      if (exp_q.size() > 0) check($sformatf("ring_addr%0d", i / 2), st_addr_q[i], exp_q.pop_front());
    end
    check("ring_exp_drained", 64'(exp_q.size()), 64'(0));
    check("ring_period", 64'(st_cyc_q[3] - st_cyc_q[1]), 64'(100));
    check("ring_epoch", 64'(epoch_id), 64'(5));
    check("ring_idx", 64'(buf_idx), 64'(1));
    check("ring_ovr", 64'(overrun_cnt), 64'(0));

    // Overrun: period 20 against updater latency 50
    do_reset();
    epoch_cycles = 0;
    done_lat     = 50;
    enable       = 1'b1;
    wait_state(S_COUNT, 200, "ovr_reach_count");
    c0 = cyc;
    epoch_cycles = 20;
    wait_wb(1, 400, "ovr_wb1");
    check("ovr_wb_start", 64'(st_cyc_q[1] - c0), 64'(20));
    check("ovr_cnt1", 64'(overrun_cnt), 64'(5));
    wait_wb(2, 400, "ovr_wb2");
    check("ovr_cnt2", 64'(overrun_cnt), 64'(10));
    check("ovr_nstarts", 64'(st_mode_q.size()), 64'(5));
    check("ovr_mode3", st_mode_q[3], 64'(WRITE_BACK_COUNTER));
    check("ovr_spacing", 64'(st_cyc_q[3] - st_cyc_q[1]), 64'(120));

    // Flush with auto-trigger disabled; two flushes during WB_WAIT collapse
    do_reset();
    epoch_cycles = 0;
    done_lat     = 10;
    enable       = 1'b1;
    wait_state(S_COUNT, 200, "flush_reach_count");
    t = cyc;
    pulse_flush();
    check("flush_lat", 64'(st_cyc_q[st_cyc_q.size() - 1] - t), 64'(1));
    check("flush_start_mode", 64'(updater_mode), 64'(WRITE_BACK_COUNTER));
    tick();
    check("flush_in_wbwait", 64'(dbg_state), 64'(S_WB_WAIT));
    pulse_flush();
    tick();
    pulse_flush();
    wait_wb(2, 200, "flush_wb2");
    repeat (300) tick();
    check("flush_nwb", 64'(count_wb()), 64'(2));
    check("flush_nwbdone", 64'(wb_cnt), 64'(2));
    check("flush_gap", 64'(st_cyc_q[3] - st_cyc_q[1]), 64'(24));
    check("flush_epoch", 64'(epoch_id), 64'(2));
    check("flush_idx", 64'(buf_idx), 64'(2));
    check("flush_ovr", 64'(overrun_cnt), 64'(0));

    // Timeout: updater never answers the write-back
    do_reset();
    epoch_cycles = 0;
    done_lat     = 10;
    enable       = 1'b1;
    wait_state(S_COUNT, 200, "tmo_reach_count");
    never_done = 1'b1;
    t = cyc;
    pulse_flush();
    while (cyc < t + 65) tick();
    check("tmo_still_wait", 64'(dbg_state), 64'(S_WB_WAIT));
    check("tmo_err_pre", 64'(timeout_err), 64'(0));
    tick();
    check("tmo_error_state", 64'(dbg_state), 64'(S_ERROR));
    check("tmo_err_set", 64'(timeout_err), 64'(1));
    check("tmo_busy", 64'(busy), 64'(0));
    n = st_mode_q.size();
    repeat (100) tick();
    check("tmo_no_starts", 64'(st_mode_q.size()), 64'(n));
    enable = 1'b0;
    tick();
    check("tmo_idle", 64'(dbg_state), 64'(S_IDLE));
    check("tmo_err_sticky", 64'(timeout_err), 64'(1));

    // Asynchronous reset in the middle of WB_WAIT
    do_reset();
    epoch_cycles = 0;
    done_lat     = 10;
    enable       = 1'b1;
    wait_state(S_COUNT, 200, "ares_reach_count");
    pulse_flush();
    wait_wb(1, 200, "ares_wb1");
    tick();
    pulse_flush();
    wait_state(S_WB_WAIT, 10, "ares_reach_wbwait");
    repeat (3) tick();
    check("ares_pre_addr", updater_buffer_addr, 64'h1040);
    check("ares_pre_epoch", 64'(epoch_id), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("ares_state", 64'(dbg_state), 64'(S_IDLE));
    check("ares_busy", 64'(busy), 64'(0));
    check("ares_mode", 64'(updater_mode), 64'(ZERO_OUT_COUNTER));
    check("ares_addr", updater_buffer_addr, 64'h0);
    check("ares_epoch", 64'(epoch_id), 64'(0));
    check("ares_idx", 64'(buf_idx), 64'(0));
    check("ares_start", 64'(updater_start), 64'(0));
    tick();
    st_mode_q.delete();
    st_addr_q.delete();
    st_cyc_q.delete();
    wb_cnt = 0;
    reset  = 1'b0;
    wait_state(S_INIT_ZO_START, 10, "ares_restart_init");
    check("ares_first_start_mode", st_mode_q.size() > 0 ? st_mode_q[0] : 64'hDEAD, 64'(ZERO_OUT_COUNTER));
    wait_state(S_COUNT, 100, "ares_back_to_count");
    check("ares_epoch_after", 64'(epoch_id), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
